// File: rtl/lcd_panel_responder.sv
`default_nettype none
// ============================================================================
// Module   : lcd_panel_responder
// Summary  : HD44780-style character panel model answering the e/rs/rw bus.
//            Optional e-width check enabled by LCD_RESP_TIMING_CHECK_EN.
// Revision : 1.0
// ============================================================================
module lcd_panel_responder #(
    parameter int CLK_FREQ = 45,
    parameter int POR_US   = 400,
    parameter int EXEC_US  = 40,
    parameter int CLEAR_US = 160,
    parameter int EMIN_US  = 5,
    parameter int CBITS    = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       e,
    input  logic       rs,
    input  logic       rw,
    input  logic [7:0] lcd_data,
    output logic [7:0] lcd_data_out,
    output logic       data_oe,
    output logic       busy_flag,
    output logic [6:0] addr,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       inc_dec,
    output logic       shift_en,
    output logic       two_line,
    output logic       font_5x10,
    output logic       err,
    input  logic [6:0] dbg_idx,
    output logic [7:0] dbg_data
);

    localparam logic [CBITS-1:0] c_POR_CYC   = CBITS'(POR_US * CLK_FREQ);
    localparam logic [CBITS-1:0] c_EXEC_CYC  = CBITS'(EXEC_US * CLK_FREQ);
    localparam logic [CBITS-1:0] c_CLEAR_CYC = CBITS'(CLEAR_US * CLK_FREQ);
    localparam logic [6:0]       c_LAST_IDX  = 7'd79;

    typedef enum logic [1:0] {
        ST_POR  = 2'd0,
        ST_IDLE = 2'd1,
        ST_BUSY = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [CBITS-1:0] r_cnt, w_cnt_nxt;
    logic             r_busy;

    logic             r_e_q, r_rs, r_rw;
    logic [7:0]       r_d;
    logic [6:0]       r_addr;
    logic             r_disp, r_cur, r_blink, r_inc, r_shift, r_two, r_font;
    logic             r_err, r_oe;
    logic [7:0]       r_dout;
    logic             r_fill_on;
    logic [6:0]       r_fill_idx;
    logic [7:0]       r_mem [0:79];

    logic             w_fall, w_width_ok, w_bf_rd, w_accept;
    logic             w_ins, w_wr_data, w_rd_data, w_do_clear, w_long, w_err_nxt;
    logic [6:0]       w_idx;
    logic             w_idx_ok;
    logic [7:0]       w_rd_byte;

    // Address counter stepping with the panel's line-wrap rules
    function automatic logic [6:0] f_step(input logic [6:0] a, input logic up,
                                          input logic two);
        if (two) begin
            if (up)
                return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
            else
                return (a == 7'h40) ? 7'h27 : (a == 7'h00) ? 7'h67 : a - 7'd1;
        end else begin
            if (up)
                return (a == 7'h4F) ? 7'h00 : a + 7'd1;
            else
                return (a == 7'h00) ? 7'h4F : a - 7'd1;
        end
    endfunction

`ifdef LCD_RESP_TIMING_CHECK_EN
    localparam logic [CBITS-1:0] c_EMIN_CYC = CBITS'(EMIN_US * CLK_FREQ);
    logic [CBITS-1:0] r_ew;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ew <= '0;
        end else if (e) begin
            if (r_ew != '1)
                r_ew <= r_ew + CBITS'(1);
        end else begin
            r_ew <= '0;
        end
    end

    assign w_width_ok = (r_ew >= c_EMIN_CYC);
`else
    logic w_unused_emin;
    assign w_unused_emin = |EMIN_US;
    assign w_width_ok    = 1'b1;
`endif

    assign w_fall     = r_e_q & ~e;
    assign w_bf_rd    = ~r_rs & r_rw;
    assign w_accept   = w_fall & w_width_ok & ~w_bf_rd & (r_state == ST_IDLE);
    assign w_ins      = w_accept & ~r_rs & ~r_rw;
    assign w_wr_data  = w_accept & r_rs & ~r_rw;
    assign w_rd_data  = w_accept & r_rs & r_rw;
    assign w_do_clear = w_ins & (r_d == 8'h01);
    assign w_long     = ~r_rs & ~r_rw & (r_d[7:2] == 6'd0) & (r_d[1:0] != 2'b00);
    assign w_err_nxt  = w_fall & (~w_width_ok | (~w_bf_rd & (r_state != ST_IDLE)));

    always_comb begin
        if (r_two) begin
            w_idx    = r_addr[6] ? (7'd40 + {1'b0, r_addr[5:0]}) : {1'b0, r_addr[5:0]};
            w_idx_ok = (r_addr[5:0] <= 6'h27);
        end else begin
            w_idx    = r_addr;
            w_idx_ok = (r_addr <= 7'h4F);
        end
    end

    assign w_rd_byte = w_idx_ok ? r_mem[w_idx] : 8'h20;
    assign dbg_data  = (dbg_idx <= c_LAST_IDX) ? r_mem[dbg_idx] : 8'h00;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = w_long ? c_CLEAR_CYC : c_EXEC_CYC;
                end
            end
            ST_POR, ST_BUSY: begin
                if (r_cnt <= CBITS'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - CBITS'(1);
                end
            end
            default: begin
                w_state_nxt = ST_POR;
                w_cnt_nxt   = c_POR_CYC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_POR;
            r_cnt   <= c_POR_CYC;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Blank-fill engine shared by power-on and the clear instruction
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fill_on  <= 1'b1;
            r_fill_idx <= '0;
        end else if (w_do_clear) begin
            r_fill_on  <= 1'b1;
            r_fill_idx <= '0;
        end else if (r_fill_on) begin
            r_fill_on  <= (r_fill_idx != c_LAST_IDX);
            r_fill_idx <= r_fill_idx + 7'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_fill_on)
                r_mem[r_fill_idx] <= 8'h20;
            else if (w_wr_data && w_idx_ok)
                r_mem[w_idx] <= r_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_e_q   <= 1'b0;
            r_rs    <= 1'b0;
            r_rw    <= 1'b0;
            r_d     <= '0;
            r_addr  <= '0;
            r_disp  <= 1'b0;
            r_cur   <= 1'b0;
            r_blink <= 1'b0;
            r_inc   <= 1'b1;
            r_shift <= 1'b0;
            r_two   <= 1'b0;
            r_font  <= 1'b0;
            r_err   <= 1'b0;
            r_oe    <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_e_q <= e;
            r_err <= w_err_nxt;
            if (e) begin
                r_rs <= rs;
                r_rw <= rw;
                r_d  <= lcd_data;
            end

            // Read data is driven from the second e-high cycle and held through the fall
            if (e && r_e_q && rw) begin
                if (!rs) begin
                    r_oe   <= 1'b1;
                    r_dout <= {r_busy, r_addr};
                end else if (r_state == ST_IDLE) begin
                    r_oe   <= 1'b1;
                    r_dout <= w_rd_byte;
                end else begin
                    r_oe   <= 1'b0;
                end
            end else if (!w_fall) begin
                r_oe <= 1'b0;
            end

            if (w_ins) begin
                casez (r_d)
                    8'b1???????: r_addr <= r_d[6:0];
                    8'b01??????: ;
                    8'b001?????: begin
                        r_two  <= r_d[3];
                        r_font <= r_d[2];
                    end
                    8'b0001????: begin
                        if (!r_d[3])
                            r_addr <= f_step(r_addr, r_d[2], r_two);
                    end
                    8'b00001???: begin
                        r_disp  <= r_d[2];
                        r_cur   <= r_d[1];
                        r_blink <= r_d[0];
                    end
                    8'b000001??: begin
                        r_inc   <= r_d[1];
                        r_shift <= r_d[0];
                    end
                    8'b0000001?: r_addr <= '0;
                    8'b00000001: begin
                        r_addr <= '0;
                        r_inc  <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (w_wr_data || w_rd_data) begin
                r_addr <= f_step(r_addr, r_inc, r_two);
            end
        end
    end

    assign lcd_data_out = r_dout;
    assign data_oe      = r_oe;
    assign busy_flag    = r_busy;
    assign addr         = r_addr;
    assign display_on   = r_disp;
    assign cursor_on    = r_cur;
    assign blink_on     = r_blink;
    assign inc_dec      = r_inc;
    assign shift_en     = r_shift;
    assign two_line     = r_two;
    assign font_5x10    = r_font;
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lcd_panel_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_panel_responder
// Summary  : Randomized self-checking bench with a panel reference model.
// Revision : 1.0
// ============================================================================
module tb_lcd_panel_responder;

`ifdef LCD_RESP_TIMING_CHECK_EN
    localparam int c_H_MIN = 225;
`else
    localparam int c_H_MIN = 1;
`endif
    localparam int c_H_RD = (c_H_MIN > 3) ? c_H_MIN : 3;

    logic       clk = 1'b0;
    logic       rst_n, e, rs, rw;
    logic [7:0] lcd_data, lcd_data_out, dbg_data;
    logic       data_oe, busy_flag, display_on, cursor_on, blink_on;
    logic       inc_dec, shift_en, two_line, font_5x10, err;
    logic [6:0] addr, dbg_idx;

    lcd_panel_responder dut (
        .clk(clk), .rst_n(rst_n), .e(e), .rs(rs), .rw(rw), .lcd_data(lcd_data),
        .lcd_data_out(lcd_data_out), .data_oe(data_oe), .busy_flag(busy_flag),
        .addr(addr), .display_on(display_on), .cursor_on(cursor_on),
        .blink_on(blink_on), .inc_dec(inc_dec), .shift_en(shift_en),
        .two_line(two_line), .font_5x10(font_5x10), .err(err),
        .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference panel state
    logic [7:0] m_ram [0:79];
    logic [6:0] m_addr;
    logic       m_disp, m_cur, m_blink, m_inc, m_shift, m_two, m_font;

    logic       busy_s, err_s;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 80; i++) m_ram[i] = 8'h20;
        m_addr = '0;
        {m_disp, m_cur, m_blink, m_shift, m_two, m_font} = '0;
        m_inc = 1'b1;
    endtask

    function automatic int m_phys(input logic [6:0] a, input logic two);
        if (!two) return (a < 80) ? int'(a) : -1;
        if (a[5:0] > 6'd39) return -1;
        return a[6] ? 40 + int'(a[5:0]) : int'(a[5:0]);
    endfunction

    // Step in linear panel order, then map back to the bus address
    function automatic logic [6:0] m_step(input logic [6:0] a, input logic up, input logic two);
        int pos;
        pos = two ? (a[6] ? 40 + int'(a[5:0]) : int'(a[5:0])) : int'(a);
        pos = (pos + (up ? 1 : 79)) % 80;
        if (!two || pos < 40) return 7'(pos);
        return 7'(pos - 40) | 7'h40;
    endfunction

    function automatic logic [6:0] m_flags();
        return {m_disp, m_cur, m_blink, m_inc, m_shift, m_two, m_font};
    endfunction

    task automatic m_cmd(input logic [7:0] d, output int n);
        n = 1800;
        if (d[7])      m_addr = d[6:0];
        else if (d[6]) ;
        else if (d[5]) begin m_two = d[3]; m_font = d[2]; end
        else if (d[4]) begin if (!d[3]) m_addr = m_step(m_addr, d[2], m_two); end
        else if (d[3]) begin m_disp = d[2]; m_cur = d[1]; m_blink = d[0]; end
        else if (d[2]) begin m_inc = d[1]; m_shift = d[0]; end
        else if (d[1]) begin m_addr = '0; n = 7200; end
        else if (d[0]) begin
            m_addr = '0; m_inc = 1'b1; n = 7200;
            for (int i = 0; i < 80; i++) m_ram[i] = 8'h20;
        end
    endtask

    task automatic do_xfer(input logic r_s, input logic r_w, input logic [7:0] d,
                           input int h, output logic oe_s, output logic [7:0] val_s);
        oe_s = 1'b0; val_s = '0;
        @(posedge clk); #1;
        e = 1'b1; rs = r_s; rw = r_w; lcd_data = d;
        for (int i = 0; i < h; i++) begin
            @(posedge clk);
            if (i == 1) begin
                @(negedge clk);
                oe_s = data_oe; val_s = lcd_data_out;
            end
        end
        #1 e = 1'b0;
        @(posedge clk);
        @(negedge clk);
        busy_s = busy_flag; err_s = err;
    endtask

    task automatic wait_idle(input int exp, input string tag);
        int n;
        n = busy_s ? 1 : 0;
        if (busy_s) begin
            while (n < 40000) begin
                @(negedge clk);
                if (!busy_flag) break;
                n++;
            end
        end
        if (exp >= 0) check(tag, n, exp);
    endtask

    task automatic sweep(input string tag);
        int bad = 0;
        for (int i = 0; i < 80; i++) begin
            dbg_idx = 7'(i); #1;
            if (dbg_data !== m_ram[i]) bad++;
        end
        check(tag, bad, 0);
    endtask

    task automatic cmd(input logic [7:0] d, input string tag);
        logic o; logic [7:0] v; int n;
        do_xfer(1'b0, 1'b0, d, c_H_MIN, o, v);
        m_cmd(d, n);
        wait_idle(n, {tag, "_busy"});
        check({tag, "_addr"}, addr, m_addr);
        check({tag, "_flags"}, {display_on, cursor_on, blink_on, inc_dec, shift_en,
                                two_line, font_5x10}, m_flags());
    endtask

    task automatic wr(input logic [7:0] d, input string tag);
        logic o; logic [7:0] v; int p;
        p = m_phys(m_addr, m_two);
        do_xfer(1'b1, 1'b0, d, c_H_MIN, o, v);
        if (p >= 0) m_ram[p] = d;
        m_addr = m_step(m_addr, m_inc, m_two);
        wait_idle(1800, {tag, "_busy"});
        check({tag, "_addr"}, addr, m_addr);
        if (p >= 0) begin
            dbg_idx = 7'(p); #1;
            check({tag, "_ram"}, dbg_data, m_ram[p]);
        end
    endtask

    task automatic rd(input string tag);
        logic o; logic [7:0] v, exp; int p;
        p = m_phys(m_addr, m_two);
        exp = (p >= 0) ? m_ram[p] : 8'h20;
        do_xfer(1'b1, 1'b1, 8'h00, c_H_RD, o, v);
        check({tag, "_oe"}, o, 1'b1);
        check({tag, "_data"}, v, exp);
        m_addr = m_step(m_addr, m_inc, m_two);
        wait_idle(1800, {tag, "_busy"});
        check({tag, "_addr"}, addr, m_addr);
    endtask

    function automatic logic [7:0] rand_addr_cmd();
        if (m_two) return {1'b1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 39))};
        return {1'b1, 7'($urandom_range(0, 79))};
    endfunction

    initial begin
        logic o; logic [7:0] v; int op;
        rst_n = 1'b0; e = 1'b0; rs = 1'b0; rw = 1'b0; lcd_data = '0; dbg_idx = '0;
        m_reset();

        // Power-on
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", busy_flag, 1'b1);
        check("rst_addr", addr, 7'h00);
        check("rst_flags", {display_on, cursor_on, blink_on, inc_dec, shift_en,
                            two_line, font_5x10}, 7'b0001000);
        check("rst_oe_err_dout", {data_oe, err, lcd_data_out}, 10'h000);
        busy_s = busy_flag;
        wait_idle(18000, "por_busy");
        sweep("por_fill");

        // Configuration sequence
        cmd(8'h38, "fset");
        cmd(8'h0E, "dctl");
        cmd(8'h06, "emode");

        // Line-end wrap in two-line mode
        cmd(8'hA7, "aset");
        wr(8'h41, "wr39");
        dbg_idx = 7'd39; #1;
        check("ram39", dbg_data, 8'h41);
        rd("rd40");

        // Ignored write and busy-flag read while busy
        do_xfer(1'b0, 1'b0, 8'h0F, c_H_MIN, o, v);
        m_cmd(8'h0F, op);
        do_xfer(1'b1, 1'b0, 8'h55, c_H_MIN, o, v);
        check("busy_wr_err", err_s, 1'b1);
        @(negedge clk);
        check("busy_wr_err_width", err, 1'b0);
        do_xfer(1'b0, 1'b1, 8'h00, c_H_RD, o, v);
        check("bf_rd_oe", o, 1'b1);
        check("bf_rd_val", v, {1'b1, m_addr});
        check("bf_rd_no_err", err_s, 1'b0);
        wait_idle(-1, "");
        check("busy_wr_addr", addr, m_addr);
        sweep("busy_wr_ram");

        // Clear restores increment mode
        cmd(8'h04, "emode_dec");
        cmd(8'h01, "clear");
        sweep("clear_fill");

        // Randomized traffic
        for (int k = 0; k < 15; k++) begin
            op = $urandom_range(0, 7);
            case (op)
                0: cmd(rand_addr_cmd(), "r_aset");
                1, 2: wr(8'($urandom), "r_wr");
                3: rd("r_rd");
                4: cmd({6'b000001, 2'($urandom)}, "r_emode");
                5: cmd({4'b0001, 4'($urandom)}, "r_shift");
                6: begin
                    cmd({3'b001, 5'($urandom)}, "r_fset");
                    cmd(rand_addr_cmd(), "r_aset2");
                end
                default: begin
                    do_xfer(1'b0, 1'b1, 8'h00, c_H_RD, o, v);
                    check("r_bf_val", v, {1'b0, m_addr});
                    check("r_bf_nobusy", busy_s, 1'b0);
                end
            endcase
        end
        sweep("rand_ram");
        dbg_idx = 7'd100; #1;
        check("dbg_oor", dbg_data, 8'h00);

`ifdef LCD_RESP_TIMING_CHECK_EN
        do_xfer(1'b1, 1'b0, 8'h77, 10, o, v);
        check("short_e_err", err_s, 1'b1);
        check("short_e_nobusy", busy_s, 1'b0);
        check("short_e_addr", addr, m_addr);
        sweep("short_e_ram");
`endif

        // Reset in the middle of a busy period
        do_xfer(1'b1, 1'b0, 8'h99, c_H_MIN, o, v);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        m_reset();
        @(negedge clk);
        check("mid_rst_busy", busy_flag, 1'b1);
        check("mid_rst_addr", addr, 7'h00);
        check("mid_rst_flags", {display_on, cursor_on, blink_on, inc_dec, shift_en,
                                two_line, font_5x10}, 7'b0001000);
        check("mid_rst_oe_err", {data_oe, err}, 2'b00);
        repeat (90) @(negedge clk);
        sweep("mid_rst_fill");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_panel_responder.md
# lcd_panel_responder

Cycle-accurate model of the HD44780-style character panel that answers our LCD initiator across the e/rs/rw/lcd_data bus. It latches bus contents while `e` is high, commits each transfer on the falling edge of `e`, and keeps the panel's state: the configuration flags, the DDRAM address counter, an 80-byte DDRAM and a timed busy flag. It sits on the panel side of the bus in simulation and formal benches, and exposes its internal state for checking.

## Interface
- `CLK_FREQ`, 45: clock cycles per µs.
- `POR_US`, 400: busy time after reset, in µs.
- `EXEC_US`, 40: busy time for normal commands and data transfers, in µs.
- `CLEAR_US`, 160: busy time for clear and return-home, in µs.
- `EMIN_US`, 5: minimum `e` high width, in µs (used only with the macro).
- `CBITS`, 15: busy counter width.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `e`, `rs`, `rw`  in  1 each  bus strobe and controls from the initiator.
- `lcd_data`  in  8  write data from the initiator.
- `lcd_data_out`  out  8  read data; reset 0.
- `data_oe`  out  1  read-data valid; reset 0.
- `busy_flag`  out  1  reset 1.
- `addr`  out  7  DDRAM address counter; reset 0.
- `display_on`, `cursor_on`, `blink_on`  out  1 each  reset 0.
- `inc_dec`  out  1  reset 1.
- `shift_en`, `two_line`, `font_5x10`  out  1 each  reset 0.
- `err`  out  1  one-cycle protocol-error pulse; reset 0.
- `dbg_idx`  in  7  DDRAM inspection index.
- `dbg_data`  out  8  combinational `DDRAM[dbg_idx]`; returns 0 when `dbg_idx` > 79.

## Operation
**States.** There are three states: POR, IDLE and BUSY.
- Reset enters POR with the busy counter loaded to `POR_US*CLK_FREQ`.
- During POR, DDRAM is filled with 0x20, one entry per cycle.
- POR and BUSY go to IDLE when the counter reaches 0. `busy_flag` is 1 in POR and BUSY, and 0 in IDLE.

**Capture.**
- In every cycle with `e`=1, the block latches `rs`, `rw` and `lcd_data`.
- A falling edge is detected when `e_q`=1 and `e`=0. On that cycle the block commits the transfer using the values latched in the last `e`-high cycle.

**Address mapping.**
- Physical index for one-line mode: `addr`. Valid range 0x00–0x4F.
- Physical index for two-line mode: `addr[6]` ? 40+`addr[5:0]` : `addr[5:0]`. Valid only when `addr[5:0]` ≤ 0x27.
- Increment wraps: 0x4F→0x00 in one-line mode; 0x27→0x40 and 0x67→0x00 in two-line mode. Decrement wraps in the reverse direction.
- An out-of-range address stores no write and reads back 0x20. The counter still steps.

**Commit actions** (any commit other than a busy-flag read loads BUSY with `EXEC_US*CLK_FREQ` unless stated otherwise). Instruction writes (`rs`=0, `rw`=0) are decoded by the highest set bit:
- 0x01, clear: fill DDRAM with 0x20 (80 cycles), set `addr`=0 and `inc_dec`=1. Busy time is `CLEAR_US`.
- 0x02/0x03, return home: set `addr`=0. Busy time is `CLEAR_US`.
- 0x04–0x07, entry mode: `inc_dec`=d[1], `shift_en`=d[0].
- 0x08–0x0F, display control: `display_on`=d[2], `cursor_on`=d[1], `blink_on`=d[0].
- 0x10–0x1F, cursor/display shift: if d[3]=0, step `addr` (d[2]=1 increments, d[2]=0 decrements). If d[3]=1, only busy is affected.
- 0x20–0x3F, function set: `two_line`=d[3], `font_5x10`=d[2].
- 0x40–0x7F, set CGRAM address: ignored; busy only.
- 0x80–0xFF, set DDRAM address: `addr`=d[6:0].

Other transfers:
- Data write (`rs`=1, `rw`=0): write d to `DDRAM[idx]`, then step `addr` by `inc_dec`.
- Data read (`rs`=1, `rw`=1): step `addr` by `inc_dec` after the read completes.
- Busy-flag read (`rs`=0, `rw`=1): no state change and no busy time. This is the only read allowed while busy.

**Errors.**
- Any other commit in POR or BUSY is ignored, and `err` pulses for 1 cycle.
- Writes are never queued.

## Timing
- All outputs are registered except `dbg_data`.
- Effects of a commit are visible on the cycle after the falling edge is detected. `busy_flag` rises on that same cycle.
- BUSY lasts exactly N cycles after the commit, then `busy_flag` drops.
- Reads: `data_oe`=1 starting from the second `e`-high cycle with `rw`=1, and drops 1 cycle after `e` falls.
  - A busy-flag read drives `lcd_data_out`={`busy_flag`, `addr`}, sampled each cycle.
  - A data read drives `lcd_data_out`=`DDRAM[idx]`.
- A clear issued during an ongoing fill restarts the fill. This can occur only after an `err`-free path.
- Reset mid-operation: all outputs return to their reset values on the next edge, and POR restarts the fill.
- `e` held high indefinitely produces no commit.

## Configuration
- `LCD_RESP_TIMING_CHECK_EN` defined: a counter measures the `e` high width. If a pulse is shorter than `EMIN_US*CLK_FREQ` cycles, the transfer is discarded and `err` pulses on the falling-edge cycle.
- Undefined: there is no width check, and a 1-cycle pulse commits normally.

## Test plan
- Reset, hold for 1 cycle, release → `busy_flag`=1 for exactly 18000 cycles, then 0; `dbg_data`=0x20 for indices 0–79.
- Function set 0x38, then display control 0x0E, then entry mode 0x06, each issued after busy clears → `two_line`=1, `font_5x10`=0, `display_on`=1, `cursor_on`=1, `blink_on`=0, `inc_dec`=1; each transfer causes 1800 busy cycles.
- Two-line mode, address set 0xA7, then data write 0x41 → `DDRAM[39]`=0x41 and `addr`=0x40; a data read then returns 0x20 and leaves `addr`=0x41.
- Data write 0x55 while busy → `err` high for 1 cycle, DDRAM unchanged; a busy-flag read in the same window returns `lcd_data_out[7]`=1 with the current `addr`.
- Clear 0x01 → `busy_flag` high for 7200 cycles, all DDRAM = 0x20, `addr`=0, `inc_dec`=1.
- With `LCD_RESP_TIMING_CHECK_EN` defined, a write with a 10-cycle `e` pulse → `err` pulse, no state change; a 225-cycle pulse commits normally.
